// File: rtl/codec_frame_serializer_if.sv
// codec_frame_serializer_if
// Bundles the datapath, command and serial-output signals of the codec
// frame serializer so that they can be passed as one port.
//   master : the side that drives bit_en, enable, samples and commands
//            and observes the serial outputs (datapath / testbench).
//   slave  : the serializer itself.
// Signals:
//   bit_en        serial bit strobe, one per bit time
//   enable        audio enable, sampled at frame start
//   sample_left   left PCM sample, two's complement
//   sample_right  right PCM sample, two's complement
//   cmd_valid     register-write request
//   cmd_addr      codec register address
//   cmd_data      codec register data
//   cmd_ready     command holding register is free
//   new_frame     one-cycle pulse after each frame-start strobe
//   sync          frame sync, high during slot 0
//   sdata_out     serial frame data, MSB first per slot
//   bit_index     frame position of the bit on sdata_out
interface codec_frame_serializer_if;
  logic        bit_en;
  logic        enable;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        new_frame;
  logic        sync;
  logic        sdata_out;
  logic [7:0]  bit_index;

  modport master (
    output bit_en, enable, sample_left, sample_right,
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, new_frame, sync, sdata_out, bit_index
  );

  modport slave (
    input  bit_en, enable, sample_left, sample_right,
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, new_frame, sync, sdata_out, bit_index
  );
endinterface

// File: rtl/codec_frame_serializer.sv
// codec_frame_serializer
// Transmit side of the codec sample link. Counts serial bit times, marks
// each frame start with new_frame, and shifts out the 256-bit frame
// (tag slot, command address/data slots, left/right PCM slots, eight
// empty slots) MSB first, one bit per bit_en. A one-deep holding register
// queues a single codec register write for the next frame.
// Ports:
//   clk       system clock
//   reset     synchronous, active-low reset
//   io_codec  slave side of codec_frame_serializer_if (see that file)
module codec_frame_serializer (
  input  logic                           clk,
  input  logic                           reset,
  codec_frame_serializer_if.slave        io_codec
);

  typedef enum logic {
    CMD_EMPTY,
    CMD_PENDING
  } cmdState_t;

  cmdState_t   r_cmdState;
  cmdState_t   w_cmdStateNext;
  logic        w_cmdReady;
  logic        w_handshake;
  logic [6:0]  r_cmdAddr;
  logic [15:0] r_cmdData;

  logic [7:0]  r_nextBit;
  logic        w_frameStart;

  logic        r_enable;
  logic        r_frameCmd;
  logic [6:0]  r_frameAddr;
  logic [15:0] r_frameData;
  logic [15:0] r_left;
  logic [15:0] r_right;

  logic        w_enable;
  logic        w_cmdPresent;
  logic [6:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] w_left;
  logic [15:0] w_right;

  logic [19:0] w_slotWord;
  logic [4:0]  w_offset;
  logic        w_bit;

  logic        r_sdata;
  logic        r_sync;
  logic        r_newFrame;
  logic [7:0]  r_bitIndex;

  // r_nextBit is the position the next bit_en will present, so a strobe
  // while it is zero (including the first one after reset) starts a frame.
  assign w_frameStart = io_codec.bit_en && (r_nextBit == 8'd0);
  assign w_handshake  = io_codec.cmd_valid && w_cmdReady;

  // Command holding register occupancy.
  always_ff @(posedge clk) begin
    if (!reset) r_cmdState <= CMD_EMPTY;
    else        r_cmdState <= w_cmdStateNext;
  end

  // A captured command waits for a frame start in a later cycle; a
  // capture coinciding with a frame start therefore rides the next frame.
  always_comb begin
    w_cmdStateNext = r_cmdState;
    w_cmdReady     = 1'b0;
    case (r_cmdState)
      CMD_EMPTY: begin
        w_cmdReady = 1'b1;
        if (io_codec.cmd_valid) w_cmdStateNext = CMD_PENDING;
      end
      CMD_PENDING: begin
        if (w_frameStart) w_cmdStateNext = CMD_EMPTY;
      end
      default: w_cmdStateNext = CMD_EMPTY;
    endcase
  end

  // Command address/data capture on handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cmdAddr <= 7'd0;
      r_cmdData <= 16'd0;
    end else if (w_handshake) begin
      r_cmdAddr <= io_codec.cmd_addr;
      r_cmdData <= io_codec.cmd_data;
    end
  end

  // Frame content, frozen for the whole frame at each frame start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_enable    <= 1'b0;
      r_frameCmd  <= 1'b0;
      r_frameAddr <= 7'd0;
      r_frameData <= 16'd0;
      r_left      <= 16'd0;
      r_right     <= 16'd0;
    end else if (w_frameStart) begin
      r_enable    <= io_codec.enable;
      r_frameCmd  <= (r_cmdState == CMD_PENDING);
      r_frameAddr <= r_cmdAddr;
      r_frameData <= r_cmdData;
      r_left      <= io_codec.sample_left;
      r_right     <= io_codec.sample_right;
    end
  end

  // Bit 0 is serialized in the same cycle the content is latched, so the
  // frame-start strobe bypasses the latches with the incoming values.
  assign w_enable     = w_frameStart ? io_codec.enable : r_enable;
  assign w_cmdPresent = w_frameStart ? (r_cmdState == CMD_PENDING) : r_frameCmd;
  assign w_addr       = w_frameStart ? r_cmdAddr : r_frameAddr;
  assign w_data       = w_frameStart ? r_cmdData : r_frameData;
  assign w_left       = w_frameStart ? io_codec.sample_left : r_left;
  assign w_right      = w_frameStart ? io_codec.sample_right : r_right;

  // Select the 20-bit slot word and the offset within it. Slot 0 is padded
  // to 20 bits on the right so every slot indexes the same way.
  always_comb begin
    w_slotWord = 20'd0;
    w_offset   = 5'd0;
    if (r_nextBit < 8'd16) begin
      w_slotWord = {w_enable, w_cmdPresent, w_cmdPresent, w_enable, w_enable, 11'd0, 4'd0};
      w_offset   = r_nextBit[4:0];
    end else if (r_nextBit < 8'd36) begin
      w_slotWord = w_cmdPresent ? {1'b0, w_addr, 12'd0} : 20'd0;
      w_offset   = 5'(r_nextBit - 8'd16);
    end else if (r_nextBit < 8'd56) begin
      w_slotWord = w_cmdPresent ? {w_data, 4'd0} : 20'd0;
      w_offset   = 5'(r_nextBit - 8'd36);
    end else if (r_nextBit < 8'd76) begin
      w_slotWord = w_enable ? {w_left, 4'd0} : 20'd0;
      w_offset   = 5'(r_nextBit - 8'd56);
    end else if (r_nextBit < 8'd96) begin
      w_slotWord = w_enable ? {w_right, 4'd0} : 20'd0;
      w_offset   = 5'(r_nextBit - 8'd76);
    end
  end

  assign w_bit = w_slotWord[5'd19 - w_offset];

  // Registered serial outputs; everything but new_frame holds between
  // strobes, and the counter wraps 255 -> 0 by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_nextBit  <= 8'd0;
      r_bitIndex <= 8'd0;
      r_sdata    <= 1'b0;
      r_sync     <= 1'b0;
      r_newFrame <= 1'b0;
    end else begin
      r_newFrame <= w_frameStart;
      if (io_codec.bit_en) begin
        r_bitIndex <= r_nextBit;
        r_sdata    <= w_bit;
        r_sync     <= (r_nextBit < 8'd16);
        r_nextBit  <= r_nextBit + 8'd1;
      end
    end
  end

  assign io_codec.cmd_ready = w_cmdReady;
  assign io_codec.new_frame = r_newFrame;
  assign io_codec.sync      = r_sync;
  assign io_codec.sdata_out = r_sdata;
  assign io_codec.bit_index = r_bitIndex;

endmodule

// File: tb/tb_codec_frame_serializer.sv
// tb_codec_frame_serializer
// Drives codec_frame_serializer with directed and randomized traffic.
// Each driven cycle updates a frame-level reference model and queues the
// expected output state; an independent monitor pops one entry per cycle
// and compares it with the DUT outputs.
module tb_codec_frame_serializer;

  logic clk = 1'b0;
  logic reset;

  codec_frame_serializer_if bus();

  codec_frame_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .io_codec (bus)
  );

  always #5 clk = ~clk;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycleCount  = 0;

  // Expected {cmd_ready, new_frame, sync, sdata_out, bit_index[7:0]}.
  logic [11:0] expQ[$];

  // Reference model state.
  int           mNext;
  logic         mPending;
  logic [6:0]   mPendAddr;
  logic [15:0]  mPendData;
  logic [255:0] mFrame;
  logic [7:0]   mIdx;
  logic         mSync;
  logic         mSdata;
  logic         mNf;

  logic         curEn;
  logic [15:0]  curL;
  logic [15:0]  curR;

  // Whole frame as a 256-bit word, frame bit 0 at the MSB.
  function automatic logic [255:0] buildFrame(input logic en, input logic hasCmd,
                                               input logic [6:0] a, input logic [15:0] d,
                                               input logic [15:0] l, input logic [15:0] r);
    logic [255:0] f;
    f = '0;
    f[255:240] = {en, hasCmd, hasCmd, en, en, 11'd0};
    if (hasCmd) begin
      f[239:220] = {1'b0, a, 12'd0};
      f[219:200] = {d, 4'd0};
    end
    if (en) begin
      f[199:180] = {l, 4'd0};
      f[179:160] = {r, 4'd0};
    end
    return f;
  endfunction

  // Apply one cycle of inputs, advance the model to the state after the
  // coming rising edge, queue the expectation, and wait for the falling edge.
  task automatic applyStimulus(input logic rstN, input logic be, input logic en,
                               input logic [15:0] l, input logic [15:0] r,
                               input logic cv, input logic [6:0] a, input logic [15:0] d);
    logic hs;
    reset            = rstN;
    bus.bit_en       = be;
    bus.enable       = en;
    bus.sample_left  = l;
    bus.sample_right = r;
    bus.cmd_valid    = cv;
    bus.cmd_addr     = a;
    bus.cmd_data     = d;
    if (!rstN) begin
      mNext    = 0;
      mPending = 1'b0;
      mIdx     = 8'd0;
      mSync    = 1'b0;
      mSdata   = 1'b0;
      mNf      = 1'b0;
      mFrame   = '0;
    end else begin
      hs  = cv && !mPending;
      mNf = 1'b0;
      if (be) begin
        if (mNext == 0) begin
          mFrame   = buildFrame(en, mPending, mPendAddr, mPendData, l, r);
          mPending = 1'b0;
        end
        mIdx   = 8'(mNext);
        mSync  = (mNext < 16);
        mSdata = mFrame[255 - mNext];
        mNf    = (mNext == 0);
        mNext  = (mNext + 1) % 256;
      end
      if (hs) begin
        mPending  = 1'b1;
        mPendAddr = a;
        mPendData = d;
      end
    end
    expQ.push_back({~mPending, mNf, mSync, mSdata, mIdx});
    cycleCount++;
    @(negedge clk);
  endtask

  task automatic checkOutput(input logic [11:0] expV);
    logic [11:0] act;
    act = {bus.cmd_ready, bus.new_frame, bus.sync, bus.sdata_out, bus.bit_index};
    testsRun++;
    if (act !== expV) begin
      testsFailed++;
      $display("[TB] FAIL outputs t=%0t actual rdy=%b nf=%b sync=%b sd=%b idx=%0d required rdy=%b nf=%b sync=%b sd=%b idx=%0d",
               $time, act[11], act[10], act[9], act[8], act[7:0],
               expV[11], expV[10], expV[9], expV[8], expV[7:0]);
    end
  endtask

  // Monitor: one expectation per clock, compared on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // period 0 means bit_en at random; cmdPct is the per-cycle request chance.
  task automatic runCycles(input int n, input int period, input bit randomData, input int cmdPct);
    for (int i = 0; i < n; i++) begin
      logic be;
      logic cv;
      if (period == 0) be = ($urandom_range(0, 2) == 0);
      else             be = ((cycleCount % period) == 0);
      if (randomData) begin
        curL = 16'($urandom);
        curR = 16'($urandom);
        if ($urandom_range(0, 199) == 0) curEn = ~curEn;
      end
      cv = ($urandom_range(0, 99) < cmdPct);
      applyStimulus(1'b1, be, curEn, curL, curR, cv, 7'($urandom), 16'($urandom));
    end
  endtask

  // Strobe every cycle until the model's next position equals target.
  task automatic runUntil(input int target);
    int guard;
    guard = 0;
    while (mNext != target && guard < 600) begin
      applyStimulus(1'b1, 1'b1, curEn, curL, curR, 1'b0, 7'd0, 16'd0);
      guard++;
    end
  endtask

  initial begin
    curEn = 1'b0;
    curL  = 16'd0;
    curR  = 16'd0;
    mPendAddr = 7'd0;
    mPendData = 16'd0;

    // Reset, with strobes present to show reset dominates.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 16'h1234, 16'h5678, 1'b1, 7'h11, 16'h2222);

    // Enabled audio, strobe every 4 cycles, one command mid-frame.
    curEn = 1'b1; curL = 16'hA5C3; curR = 16'h8001;
    runCycles(600, 4, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, curEn, curL, curR, 1'b1, 7'h02, 16'h0808);
    runCycles(2 * 1024, 4, 1'b0, 0);

    // Audio disabled with nonzero samples, plus a command.
    curEn = 1'b0; curL = 16'h7FFF; curR = 16'hFFFF;
    runCycles(400, 4, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, curEn, curL, curR, 1'b1, 7'h02, 16'h0808);
    runCycles(1500, 4, 1'b0, 0);

    // Randomized content at full bit rate.
    runCycles(256 * 14, 1, 1'b1, 3);

    // Handshake in the same cycle as a frame-start strobe.
    curEn = 1'b1;
    runCycles(300, 1, 1'b0, 0);
    runUntil(0);
    applyStimulus(1'b1, 1'b1, curEn, curL, curR, 1'b1, 7'h5A, 16'hC3A5);
    runCycles(600, 1, 1'b0, 0);

    // Reset at bit 100 with a command pending.
    runUntil(50);
    applyStimulus(1'b1, 1'b1, curEn, curL, curR, 1'b1, 7'h33, 16'hBEEF);
    runUntil(101);
    repeat (2) applyStimulus(1'b0, 1'b1, curEn, curL, curR, 1'b0, 7'd0, 16'd0);
    runCycles(600, 1, 1'b0, 0);

    // Irregular strobe spacing with random traffic.
    runCycles(1800, 0, 1'b1, 2);

    bus.bit_en    = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
